// File: rtl/wb_pipe_checker_if.sv
// rtl/wb_pipe_checker_if.sv - pipelined Wishbone B4 bus bundle
//
// Groups the master and slave signals of one classic pipelined Wishbone link.
//   master  : drives cyc/stb/we/adr/sel/dat_m, observes stall/ack/err/dat_s
//   slave   : drives stall/ack/err/dat_s, observes the master signals
//   monitor : observes everything, drives nothing (used by wb_pipe_checker)
interface wb_pipe_checker_if #(
    parameter int ADR_WIDTH = 32,
    parameter int DAT_WIDTH = 32
);
    logic                   cyc;
    logic                   stb;
    logic                   we;
    logic [ADR_WIDTH-1:0]   adr;
    logic [DAT_WIDTH/8-1:0] sel;
    logic [DAT_WIDTH-1:0]   dat_m;
    logic                   stall;
    logic                   ack;
    logic                   err;
    logic [DAT_WIDTH-1:0]   dat_s;

    modport master (
        output cyc, stb, we, adr, sel, dat_m,
        input  stall, ack, err, dat_s
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_m,
        output stall, ack, err, dat_s
    );

    modport monitor (
        input cyc, stb, we, adr, sel, dat_m, stall, ack, err, dat_s
    );
endinterface

// File: rtl/wb_pipe_checker.sv
// rtl/wb_pipe_checker.sv - stateful protocol checker for pipelined Wishbone B4
//
// Passive monitor: tracks outstanding requests, response timeout, stall hold
// stability and response legality; reports violations as registered pulses.
// Optional X/Z checking (code 8) is enabled by defining WB_PIPE_CHECKER_XCHECK_EN.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus          wb_pipe_checker_if.monitor, observed bus (never driven)
//   outstanding  accepted-but-unanswered request count
//   violation    one-cycle registered pulse when a check fails
//   viol_code    code of the reported violation (lowest wins), valid with violation
//   viol_sticky  set by any violation, cleared only by rst
//   req_count, ack_count, err_count  saturating statistics
//
// Violation codes: 1 ack&err, 2 unsolicited response, 3 overflow, 4 timeout,
// 5 cyc dropped with outstanding, 6 cyc/stb dropped in stall, 7 request changed
// in stall, 8 X/Z on bus.
module wb_pipe_checker #(
    parameter int ADR_WIDTH       = 32,
    parameter int DAT_WIDTH       = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAXWAITS        = 16,
    parameter int CNT_WIDTH       = 16,
    localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_pipe_checker_if.monitor   bus,
    output logic [OW-1:0]        outstanding,
    output logic                 violation,
    output logic [3:0]           viol_code,
    output logic                 viol_sticky,
    output logic [CNT_WIDTH-1:0] req_count,
    output logic [CNT_WIDTH-1:0] ack_count,
    output logic [CNT_WIDTH-1:0] err_count
);
    localparam int WW = $clog2(MAXWAITS + 1);
    localparam int SW = DAT_WIDTH / 8;
    localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUTSTANDING);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAXWAITS - 1);

    logic [OW-1:0]        outstanding_q, outstanding_d;
    logic [WW-1:0]        wait_q, wait_d;
    logic                 hold_q, hold_d;
    logic [ADR_WIDTH-1:0] adr_q, adr_d;
    logic                 we_q, we_d;
    logic [SW-1:0]        sel_q, sel_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;
    logic                 violation_q, violation_d;
    logic [3:0]           code_q, code_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] req_q, req_d, ack_q, ack_d, err_q, err_d;

    logic accept, resp, timeout, x_fail;
    logic c_both, c_unsol, c_ovf, c_drop, c_hold_drop, c_hold_chg;

`ifdef WB_PIPE_CHECKER_XCHECK_EN
    always_comb begin
        x_fail = 1'b0;
        if ($isunknown(bus.cyc)) begin
            x_fail = 1'b1;
        end else if (bus.cyc) begin
            if ($isunknown({bus.stb, bus.stall, bus.ack, bus.err})) begin
                x_fail = 1'b1;
            end else begin
                if (bus.stb && $isunknown({bus.adr, bus.sel, bus.we}))
                    x_fail = 1'b1;
                if (bus.stb && bus.we && $isunknown(bus.dat_m))
                    x_fail = 1'b1;
                if (!bus.we && (bus.ack || bus.err) && $isunknown(bus.dat_s))
                    x_fail = 1'b1;
            end
        end
    end
`else
    // Read data is only inspected by the X/Z check.
    logic unused_dat_s;
    assign unused_dat_s = ^bus.dat_s;
    assign x_fail       = 1'b0;
`endif

    always_comb begin
        accept  = bus.cyc & bus.stb & ~bus.stall;
        resp    = bus.cyc & (bus.ack | bus.err);
        c_both  = bus.cyc & bus.ack & bus.err;
        // A response in the same cycle as the first accept is still unsolicited.
        c_unsol = resp & (outstanding_q == '0);
        c_ovf   = accept & ~resp & (outstanding_q == OUT_MAX);
        c_drop  = ~bus.cyc & (outstanding_q != '0);
        c_hold_drop = hold_q & ~(bus.cyc & bus.stb);
        c_hold_chg  = hold_q & ((bus.adr != adr_q) | (bus.we != we_q) |
                                (bus.sel != sel_q) |
                                (we_q & (bus.dat_m != dat_q)));

        // Outstanding count, clamped at 0 and MAX; a dropped cycle abandons all.
        outstanding_d = outstanding_q;
        if (c_drop)
            outstanding_d = '0;
        else if (accept && !resp && outstanding_q != OUT_MAX)
            outstanding_d = outstanding_q + OW'(1);
        else if (resp && !accept && outstanding_q != '0)
            outstanding_d = outstanding_q - OW'(1);

        // Wait counter restarts after each timeout so one report per window.
        timeout = 1'b0;
        wait_d  = '0;
        if (!(c_drop || resp || outstanding_q == '0)) begin
            if (wait_q == WAIT_LAST)
                timeout = 1'b1;
            else
                wait_d = wait_q + WW'(1);
        end

        hold_d = bus.cyc & bus.stb & bus.stall;
        adr_d  = hold_d ? bus.adr : adr_q;
        we_d   = hold_d ? bus.we  : we_q;
        sel_d  = hold_d ? bus.sel : sel_q;
        dat_d  = (hold_d && bus.we) ? bus.dat_m : dat_q;

        code_d = 4'd0;
        if      (c_both)      code_d = 4'd1;
        else if (c_unsol)     code_d = 4'd2;
        else if (c_ovf)       code_d = 4'd3;
        else if (timeout)     code_d = 4'd4;
        else if (c_drop)      code_d = 4'd5;
        else if (c_hold_drop) code_d = 4'd6;
        else if (c_hold_chg)  code_d = 4'd7;
        else if (x_fail)      code_d = 4'd8;
        violation_d = (code_d != 4'd0);
        sticky_d    = sticky_q | violation_d;

        req_d = req_q;
        ack_d = ack_q;
        err_d = err_q;
        if (accept && !(&req_q))               req_d = req_q + CNT_WIDTH'(1);
        if (bus.cyc && bus.ack && !(&ack_q))   ack_d = ack_q + CNT_WIDTH'(1);
        if (bus.cyc && bus.err && !(&err_q))   err_d = err_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_q <= '0;
            wait_q        <= '0;
            hold_q        <= 1'b0;
            adr_q         <= '0;
            we_q          <= 1'b0;
            sel_q         <= '0;
            dat_q         <= '0;
            violation_q   <= 1'b0;
            code_q        <= 4'd0;
            sticky_q      <= 1'b0;
            req_q         <= '0;
            ack_q         <= '0;
            err_q         <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            wait_q        <= wait_d;
            hold_q        <= hold_d;
            adr_q         <= adr_d;
            we_q          <= we_d;
            sel_q         <= sel_d;
            dat_q         <= dat_d;
            violation_q   <= violation_d;
            code_q        <= code_d;
            sticky_q      <= sticky_d;
            req_q         <= req_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
        end
    end

    assign outstanding = outstanding_q;
    assign violation   = violation_q;
    assign viol_code   = code_q;
    assign viol_sticky = sticky_q;
    assign req_count   = req_q;
    assign ack_count   = ack_q;
    assign err_count   = err_q;
endmodule
